poly_tone_generator: RTL and testbench

POLY_TONE_GENERATOR -- requirements
Module: poly_tone_generator

---
 rtl/synth_pkg.sv | 51 +++++
 rtl/tone_voice.sv | 55 +++++
 rtl/poly_tone_generator.sv | 231 +++++++++++++++++++++++
 tb/tb_poly_tone_generator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_pkg
// Description : Shared constants and types for the polyphonic tone generator:
//               octave-0 period table, waveform mode encoding, octave limit.
// Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    // Highest octave shift applied to the base periods
    localparam int OCT_MAX_DEFAULT = 4;

    // Octave-0 periods (clock cycles per tone period at 10 MHz), C2 .. C3
    localparam int DIV_BASE_W   = 18;
    localparam int DIV_BASE_LEN = 13;
    localparam logic [DIV_BASE_W-1:0] DIV_BASE [DIV_BASE_LEN] = '{
        18'd152905,  // C2
        18'd144309,  // C#2
        18'd136210,  // D2
        18'd128565,  // D#2
        18'd121349,  // E2
        18'd114538,  // F2
        18'd108110,  // F#2
        18'd102042,  // G2
        18'd96316,   // G#2
        18'd90909,   // A2
        18'd85807,   // A#2
        18'd80991,   // B2
        18'd76453    // C3
    };

    // Waveform selection; advances in this order on each mode press
    typedef enum logic [1:0] {
        MODE_SQUARE  = 2'd0,  // 50% duty
        MODE_PULSE25 = 2'd1,  // 25% duty
        MODE_PULSE12 = 2'd2,  // 12.5% duty
        MODE_MUTE    = 2'd3   // silent
    } mode_t;

    // Table lookup; keys outside the table yield a zero period (silent voice)
    function automatic logic [DIV_BASE_W-1:0] div_base(input int idx);
        logic [DIV_BASE_W-1:0] result;
        result = '0;
        if (idx >= 0 && idx < DIV_BASE_LEN) begin
            result = DIV_BASE[idx];
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_voice.sv
`default_nettype none
// ============================================================================
// Module      : tone_voice
// Description : One voice: phase counter running 0..period-1 and the duty
//               comparator producing the voice's 1-bit sample.
// Revision    : 1.0 - initial release
// ============================================================================
module tone_voice
    import synth_pkg::*;
#(
    parameter int DIV_WIDTH = 18
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 restart,
    input  logic                 busy,
    input  logic [DIV_WIDTH-1:0] period,
    input  mode_t                mode,
    output logic                 sample
);

    logic [DIV_WIDTH-1:0] r_phase;
    logic [DIV_WIDTH-1:0] w_phase_inc;
    logic [DIV_WIDTH-1:0] w_threshold;

    assign w_phase_inc = r_phase + DIV_WIDTH'(1);

    // Phase counter: restarts on reassignment or idle, wraps at the period.
    // The >= compare also recovers cleanly when an octave change shrinks the period.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_phase <= '0;
        end else if (restart || !busy) begin
            r_phase <= '0;
        end else if (w_phase_inc >= period) begin
            r_phase <= '0;
        end else begin
            r_phase <= w_phase_inc;
        end
    end

    // Duty comparator: high-phase length is the period scaled by the mode
    always_comb begin
        w_threshold = '0;
        case (mode)
            MODE_SQUARE:  w_threshold = period >> 1;
            MODE_PULSE25: w_threshold = period >> 2;
            MODE_PULSE12: w_threshold = period >> 3;
            default:      w_threshold = '0;
        endcase
        sample = busy && (r_phase < w_threshold);
    end

endmodule
`default_nettype wire

// File: rtl/poly_tone_generator.sv
`default_nettype none
// ============================================================================
// Module      : poly_tone_generator
// Description : Keyboard-driven polyphonic square/pulse synthesiser. Keys are
//               synchronised, allocated to voices lowest-index first, and the
//               voice samples are mixed into a single PWM audio output.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_tone_generator
    import synth_pkg::*;
#(
    parameter int NUM_KEYS   = 13,
    parameter int NUM_VOICES = 4,
    parameter int DIV_WIDTH  = 18,
    parameter int PWM_WIDTH  = 8,
    parameter int OCT_MAX    = OCT_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cs,
    input  logic [NUM_KEYS-1:0]   keys,
    input  logic                  octave_up,
    input  logic                  octave_down,
    input  logic                  mode_key,
    output logic                  pwm_out,
    output logic [2:0]            octave,
    output logic [1:0]            mode,
    output logic [NUM_VOICES-1:0] voice_busy
);

    localparam int KEY_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int IN_W        = NUM_KEYS + 3;
    localparam int SUM_W       = $clog2(NUM_VOICES) + 1;
    localparam int LEVEL_W     = PWM_WIDTH + 1;
    localparam int VOICE_SHIFT = PWM_WIDTH - $clog2(NUM_VOICES);
    localparam logic [2:0] OCT_TOP   = 3'(OCT_MAX);
    localparam logic [2:0] OCT_RESET = 3'd2;

    // ---------------- input gating and synchroniser ----------------
    logic [IN_W-1:0] w_raw;
    logic [IN_W-1:0] r_sync1;
    logic [IN_W-1:0] r_sync2;
    logic [NUM_KEYS-1:0] w_keys_s;
    logic [2:0] w_ctl;          // [0]=up, [1]=down, [2]=mode

    assign w_raw    = cs ? '0 : {mode_key, octave_down, octave_up, keys};
    assign w_keys_s = r_sync2[NUM_KEYS-1:0];
    assign w_ctl    = r_sync2[IN_W-1:NUM_KEYS];

    // Two-flop synchroniser for all key inputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // ---------------- control edge detection ----------------
    logic [2:0] r_ctl_prev;
    logic [1:0] r_warm;
    logic       w_armed;
    logic [2:0] w_edge;
    logic       w_up_edge;
    logic       w_down_edge;
    logic       w_mode_edge;

    // Edges are suppressed until the synchroniser has filled after reset, so a
    // key held through reset is not mistaken for a fresh press.
    assign w_armed     = (r_warm == 2'd3);
    assign w_edge      = w_ctl & ~r_ctl_prev & {3{w_armed}};
    assign w_up_edge   = w_edge[0];
    assign w_down_edge = w_edge[1];
    assign w_mode_edge = w_edge[2];

    // Previous control levels and post-reset warm-up counter
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ctl_prev <= '0;
            r_warm     <= '0;
        end else begin
            r_ctl_prev <= w_ctl;
            if (!w_armed) begin
                r_warm <= r_warm + 2'd1;
            end
        end
    end

    // ---------------- octave ----------------
    logic [2:0] r_octave;

    // Saturating octave shift; simultaneous up and down cancel
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_octave <= OCT_RESET;
        end else if (w_up_edge && !w_down_edge && (r_octave < OCT_TOP)) begin
            r_octave <= r_octave + 3'd1;
        end else if (w_down_edge && !w_up_edge && (r_octave != 3'd0)) begin
            r_octave <= r_octave - 3'd1;
        end
    end

    // ---------------- waveform mode state machine ----------------
    mode_t r_mode;
    mode_t w_mode_next;

    // Mode state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_mode <= MODE_SQUARE;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    // Mode sequencing: square -> 25% -> 12.5% -> mute -> square
    always_comb begin
        w_mode_next = r_mode;
        if (w_mode_edge) begin
            case (r_mode)
                MODE_SQUARE:  w_mode_next = MODE_PULSE25;
                MODE_PULSE25: w_mode_next = MODE_PULSE12;
                MODE_PULSE12: w_mode_next = MODE_MUTE;
                default:      w_mode_next = MODE_SQUARE;
            endcase
        end
    end

    // ---------------- voice allocation ----------------
    logic [NUM_VOICES-1:0] w_next_busy;
    logic [KEY_W-1:0]      w_next_key [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_voice_busy;
    logic [KEY_W-1:0]      r_voice_key [NUM_VOICES];

    // Voice v takes the v-th lowest held key; keys beyond the last voice are dropped
    always_comb begin : p_assign
        int slot;
        slot        = 0;
        w_next_busy = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_next_key[v] = '0;
        end
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (w_keys_s[k]) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (slot == v) begin
                        w_next_busy[v] = 1'b1;
                        w_next_key[v]  = KEY_W'(k);
                    end
                end
                slot = slot + 1;
            end
        end
    end

    // Registered voice assignment
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_voice_busy <= '0;
            r_voice_key  <= '{default: '0};
        end else begin
            r_voice_busy <= w_next_busy;
            r_voice_key  <= w_next_key;
        end
    end

    // ---------------- voices ----------------
    logic [NUM_VOICES-1:0] w_sample;
    logic [DIV_WIDTH-1:0]  w_period [NUM_VOICES];

    // Per-voice period: base period of the assigned key shifted by the octave
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_period[v] = DIV_WIDTH'(div_base(int'(r_voice_key[v]))) >> r_octave;
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        logic w_restart;

        // Phase restarts when the voice is about to change key or go idle
        assign w_restart = !w_next_busy[v] || !r_voice_busy[v] ||
                           (w_next_key[v] != r_voice_key[v]);

        tone_voice #(
            .DIV_WIDTH (DIV_WIDTH)
        ) u_voice (
            .clk     (clk),
            .nrst    (nrst),
            .restart (w_restart),
            .busy    (r_voice_busy[v]),
            .period  (w_period[v]),
            .mode    (r_mode),
            .sample  (w_sample[v])
        );
    end

    // ---------------- mixer and PWM ----------------
    logic [SUM_W-1:0]     w_sum;
    logic [LEVEL_W-1:0]   w_level;
    logic [PWM_WIDTH-1:0] r_carrier;

    // Count of voices currently high
    always_comb begin
        w_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_sum = w_sum + SUM_W'(w_sample[v]);
        end
    end

    // Full scale (all voices high) maps to 2^PWM_WIDTH, above every carrier value
    assign w_level = LEVEL_W'(w_sum) << VOICE_SHIFT;

    // Free-running PWM carrier
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_carrier <= '0;
        end else begin
            r_carrier <= r_carrier + PWM_WIDTH'(1);
        end
    end

    assign pwm_out    = !cs && ((&w_sample) || ({1'b0, r_carrier} < w_level));
    assign octave     = r_octave;
    assign mode       = r_mode;
    assign voice_busy = r_voice_busy;

endmodule
`default_nettype wire

// File: tb/tb_poly_tone_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_tone_generator
// Description : Self-checking bench for poly_tone_generator: directed scenarios
//               plus randomized key traffic against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_tone_generator;

    localparam int NUM_KEYS   = 13;
    localparam int NUM_VOICES = 4;
    localparam int DIV_WIDTH  = 18;
    localparam int PWM_WIDTH  = 8;
    localparam int OCT_MAX    = 4;

    // Octave-0 tone periods at 10 MHz, C2..C3
    localparam int BASE [NUM_KEYS] = '{152905, 144309, 136210, 128565, 121349, 114538,
                                       108110, 102042, 96316, 90909, 85807, 80991, 76453};

    logic                  clk = 1'b0;
    logic                  nrst;
    logic                  cs;
    logic [NUM_KEYS-1:0]   keys;
    logic                  octave_up;
    logic                  octave_down;
    logic                  mode_key;
    logic                  pwm_out;
    logic [2:0]            octave;
    logic [1:0]            mode;
    logic [NUM_VOICES-1:0] voice_busy;

    always #5 clk = ~clk;

    poly_tone_generator #(
        .NUM_KEYS   (NUM_KEYS),
        .NUM_VOICES (NUM_VOICES),
        .DIV_WIDTH  (DIV_WIDTH),
        .PWM_WIDTH  (PWM_WIDTH),
        .OCT_MAX    (OCT_MAX)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .cs          (cs),
        .keys        (keys),
        .octave_up   (octave_up),
        .octave_down (octave_down),
        .mode_key    (mode_key),
        .pwm_out     (pwm_out),
        .octave      (octave),
        .mode        (mode),
        .voice_busy  (voice_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Inputs reach the logic two cycles late; presses are 0->1 transitions of
    // that delayed view, ignored for the first three cycles after reset.
    typedef struct packed {
        logic [15:0]                  s1;
        logic [15:0]                  s2;
        logic [2:0]                   prev_ctl;
        logic [7:0]                   age;
        logic [2:0]                   oct;
        logic [1:0]                   mode;
        logic [7:0]                   carrier;
        logic [NUM_VOICES-1:0]        vbusy;
        logic [NUM_VOICES-1:0][3:0]   vkey;
        logic [NUM_VOICES-1:0][31:0]  phase;
    } model_t;

    function automatic model_t model_reset();
        model_t r;
        r     = '0;
        r.oct = 3'd2;
        return r;
    endfunction

    function automatic model_t model_next(input model_t m, input logic [15:0] raw);
        model_t     n;
        logic [2:0] press;
        int         held [NUM_KEYS];
        int         cnt;
        int         per;
        int         nk;
        bit         nb;
        n   = m;
        cnt = 0;
        for (int k = 0; k < NUM_KEYS; k++) held[k] = 0;
        press = m.s2[15:13] & ~m.prev_ctl;
        if (m.age < 3) press = 3'b000;
        n.s1       = raw;
        n.s2       = m.s1;
        n.prev_ctl = m.s2[15:13];
        if (m.age < 3) n.age = m.age + 8'd1;
        if (press[0] && !press[1] && m.oct < OCT_MAX) n.oct = m.oct + 3'd1;
        else if (press[1] && !press[0] && m.oct > 0) n.oct = m.oct - 3'd1;
        if (press[2]) n.mode = m.mode + 2'd1;
        n.carrier = m.carrier + 8'd1;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (m.s2[k]) begin
                held[cnt] = k;
                cnt++;
            end
        end
        for (int v = 0; v < NUM_VOICES; v++) begin
            nb = (v < cnt);
            nk = nb ? held[v] : 0;
            if (!nb || !m.vbusy[v] || nk != int'(m.vkey[v])) begin
                n.phase[v] = 0;
            end else begin
                per = BASE[m.vkey[v]] >> m.oct;
                n.phase[v] = (int'(m.phase[v]) + 1 >= per) ? 0 : m.phase[v] + 1;
            end
            n.vbusy[v] = nb;
            n.vkey[v]  = 4'(nk);
        end
        return n;
    endfunction

    function automatic bit exp_pwm(input model_t m, input logic cs_now);
        int s;
        int per;
        int thr;
        int level;
        s = 0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (m.vbusy[v] && m.mode != 2'd3) begin
                per = BASE[m.vkey[v]] >> m.oct;
                thr = per >> (int'(m.mode) + 1);
                if (int'(m.phase[v]) < thr) s++;
            end
        end
        level = s * ((1 << PWM_WIDTH) / NUM_VOICES);
        return !cs_now && (int'(m.carrier) < level);
    endfunction

    model_t      m;
    logic [15:0] raw_in;
    bit          chk_en = 1'b0;

    assign raw_in = cs ? 16'd0 : {mode_key, octave_down, octave_up, keys};

    always @(posedge clk or negedge nrst) begin
        if (!nrst) m <= model_reset();
        else       m <= model_next(m, raw_in);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_pwm_out", pwm_out, exp_pwm(m, cs));
            check("model_voice_busy", voice_busy, m.vbusy);
            check("model_octave", octave, m.oct);
            check("model_mode", mode, m.mode);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic press(input bit up, input bit dn, input bit md);
        octave_up = up; octave_down = dn; mode_key = md;
        tick(4);
        octave_up = 1'b0; octave_down = 1'b0; mode_key = 1'b0;
        tick(4);
    endtask

    task automatic count_high(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm_out) c++;
            tick(1);
        end
    endtask

    initial begin
        int c;
        int exp_oct;

        // Reset with octave_up and mode_key held through it
        nrst = 1'b0; cs = 1'b0; keys = '0;
        octave_up = 1'b1; octave_down = 1'b0; mode_key = 1'b1;
        tick(3);
        chk_en = 1'b1;
        check("reset_octave", octave, 2);
        check("reset_mode", mode, 0);
        check("reset_voice_busy", voice_busy, 0);
        check("reset_pwm_out", pwm_out, 0);
        nrst = 1'b1;
        tick(10);
        check("held_through_reset_octave", octave, 2);
        check("held_through_reset_mode", mode, 0);
        octave_up = 1'b0; mode_key = 1'b0;
        tick(5);

        // Octave saturation and cancellation
        exp_oct = 2;
        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0, 1'b0);
            exp_oct = (exp_oct < OCT_MAX) ? exp_oct + 1 : OCT_MAX;
            check("octave_up", octave, exp_oct);
        end
        for (int i = 0; i < 6; i++) begin
            press(1'b0, 1'b1, 1'b0);
            exp_oct = (exp_oct > 0) ? exp_oct - 1 : 0;
            check("octave_down", octave, exp_oct);
        end
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("octave_back_to_2", octave, 2);
        press(1'b1, 1'b1, 1'b0);
        check("octave_up_down_same_cycle", octave, 2);

        // Mode cycle
        for (int i = 0; i < 4; i++) begin
            press(1'b0, 1'b0, 1'b1);
            check("mode_cycle", mode, (i + 1) % 4);
        end

        // Key 9, octave 2, square: period 22727, 25% carrier duty in the high half
        keys = 13'h0200;
        tick(3);
        check("key9_voice_busy", voice_busy, 4'b0001);
        tick(100);
        count_high(256, c);
        check("key9_duty_high_half", c, 64);
        tick(11500 - 356);
        count_high(256, c);
        check("key9_duty_low_half", c, 0);
        tick(22727 + 100 - 11756);
        count_high(256, c);
        check("key9_duty_after_wrap", c, 64);

        // All voices started together: every sample high, output held at 1
        keys = '0;
        tick(5);
        keys = 13'h000F;
        tick(3);
        count_high(256, c);
        check("all_voices_high_pwm", c, 256);

        // Five held keys on four voices, then release key 3
        keys = '0;
        tick(5);
        keys = 13'h02A9;   // keys 0,3,5,7,9
        tick(3);
        check("five_keys_voice_busy", voice_busy, 4'b1111);
        tick(1500);
        keys = 13'h02A1;   // release key 3
        tick(3);
        check("release_key3_voice_busy", voice_busy, 4'b1111);
        tick(1500);

        // Mute mode silences held keys
        for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1'b1);
        check("mute_mode", mode, 3);
        count_high(300, c);
        check("mute_pwm_silent", c, 0);
        press(1'b0, 1'b0, 1'b1);
        check("mode_wrap_to_0", mode, 0);

        // Chip select high with keys held
        tick(20);
        cs = 1'b1;
        #1;
        check("cs_pwm_immediate", pwm_out, 0);
        tick(3);
        check("cs_voice_busy", voice_busy, 0);
        cs = 1'b0;
        tick(10);

        // Randomized traffic at octave 4
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("random_start_octave", octave, 4);
        for (int s = 0; s < 25; s++) begin
            keys = 13'($urandom & $urandom & $urandom);
            cs   = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 4))
                0: press(1'b1, 1'b0, 1'b0);
                1: press(1'b0, 1'b1, 1'b0);
                2: press(1'b0, 1'b0, 1'b1);
                default: tick(1);
            endcase
            tick($urandom_range(500, 2500));
        end
        cs = 1'b0;

        // Reset mid-note with control keys held
        keys = 13'h0411;
        tick(200);
        octave_up = 1'b1; mode_key = 1'b1;
        #1;
        nrst = 1'b0;
        #1;
        check("midnote_reset_octave", octave, 2);
        check("midnote_reset_mode", mode, 0);
        check("midnote_reset_voice_busy", voice_busy, 0);
        check("midnote_reset_pwm_out", pwm_out, 0);
        tick(2);
        nrst = 1'b1;
        tick(10);
        check("midnote_after_release_octave", octave, 2);
        check("midnote_after_release_mode", mode, 0);
        check("midnote_after_release_busy", voice_busy, 4'b0111);
        octave_up = 1'b0; mode_key = 1'b0; keys = '0;
        tick(10);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
